main_mem: RTL and testbench
===========================

MAIN_MEM -- requirements
Module: main_mem

Interface
REQ-001 Parameter DEPTH_WORDS, default 65536, storage size in 32-bit words (power of two).
REQ-002 Parameter LINE_WORDS, default 4, words per burst (power of two, >=2).
REQ-003 Parameter LATENCY, default 3, access delay in cycles (>=1).
REQ-004 Port clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port req_valid  input  1  cache-side line request present.
REQ-007 Port req_ready  output  1  request accepted when req_valid && req_ready at a clock edge.
REQ-008 Port req_write  input  1  1 = line writeback, 0 = line refill.
REQ-009 Port req_addr  input  32  byte address of the request.
REQ-010 Port wdata  input  32  writeback beat data.
REQ-011 Port wdata_valid  input  1  writeback beat present.
REQ-012 Port wdata_ready  output  1  beat consumed when wdata_valid && wdata_ready at a clock edge.
REQ-013 Port rdata  output  32  refill beat data.
REQ-014 Port rdata_valid  output  1  refill beat valid; no backpressure.
REQ-015 Port rdata_last  output  1  high with the final refill beat.
REQ-016 Port wr_done  output  1  one-cycle pulse when a writeback has completed.

Function
REQ-017 The FSM SHALL use states IDLE, WR_BURST, LAT, RD_BURST, WR_ACK.
REQ-018 req_ready SHALL be 1 only in IDLE; req_valid in any other state is ignored and not latched.
REQ-019 On acceptance the block SHALL latch req_write and the line base word index = (req_addr[31:2] mod DEPTH_WORDS) with the low log2(LINE_WORDS) bits cleared.
REQ-020 Refill: IDLE -> LAT; LAT lasts LATENCY cycles; RD_BURST drives LINE_WORDS beats on consecutive cycles; then IDLE.
REQ-021 With acceptance edge ending cycle 0, rdata_valid SHALL be high in cycles LATENCY+1 .. LATENCY+LINE_WORDS, and rdata_last only in the last of these.
REQ-022 Writeback: IDLE -> WR_BURST; wdata_ready=1 throughout WR_BURST; the beat counter advances only on handshake; gaps in wdata_valid stall without error.
REQ-023 Each accepted beat SHALL be written to storage at the same edge; after beat LINE_WORDS-1 go to LAT, then WR_ACK (wr_done=1 for one cycle), then IDLE.
REQ-024 Beat addresses SHALL wrap within the line (modulo LINE_WORDS), never crossing into the next line.
REQ-025 Outside RD_BURST, rdata SHALL be 0 and rdata_valid/rdata_last 0; wdata_valid outside WR_BURST SHALL be ignored.
REQ-026 A refill issued after a wr_done to the same line SHALL return the written data.

Reset
REQ-027 While rst=1: state=IDLE, counters=0, all outputs 0 (including req_ready); first cycle after deassertion req_ready=1.
REQ-028 Reset mid-operation SHALL abort the transaction with no wr_done/rdata_last; beats already written stay; storage is never cleared by reset.

Configuration
REQ-029 Macro MAIN_MEM_CRITICAL_WORD_FIRST_EN defined: refill burst SHALL start at the requested word (req_addr[..:2]) and wrap within the line; writeback order unchanged.
REQ-030 Macro undefined: every burst SHALL start at line offset 0.

Structure
REQ-031 Package main_mem_pkg SHALL hold the FSM state enum and the default LINE_WORDS/LATENCY constants, shared with the cache-side memory unit.
REQ-032 Storage SHALL be a sub-module mem_array (synchronous write, combinational read, DEPTH_WORDS x 32).

Verification
REQ-033 Refill at 0x0000_0010 after preloading words 4..7 = 0xA0..0xA3 -> rdata_valid cycles 4-7 with 0xA0,0xA1,0xA2,0xA3, rdata_last in cycle 7.
REQ-034 With CWF_EN, refill at 0x0000_0018 -> beats 0xA2,0xA3,0xA0,0xA1; without it -> 0xA0..0xA3.
REQ-035 Writeback at 0x40 with wdata_valid gapped (1,0,1,1,0,1), data 0x11..0x44 -> four writes, wr_done once, then refill of 0x40 returns 0x11..0x44.
REQ-036 req_valid held high during a refill -> second request accepted only in the first IDLE cycle after the burst; no duplicate beats.
REQ-037 rst asserted during the second refill beat -> next cycle all outputs 0, no rdata_last; next request served normally.
REQ-038 Address 0xFFFF_FFF0 with DEPTH_WORDS=65536 -> maps to words 0xFFFC..0xFFFF; no out-of-range access.

Source files
------------

// File: rtl/main_mem_pkg.sv
// Shared definitions for main_mem and the cache-side memory unit:
// FSM state encoding and default line/latency geometry.
package main_mem_pkg;

    localparam int DATA_W          = 32;
    localparam int DEF_DEPTH_WORDS = 65536;
    localparam int DEF_LINE_WORDS  = 4;
    localparam int DEF_LATENCY     = 3;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_BURST = 3'd1,
        LAT      = 3'd2,
        RD_BURST = 3'd3,
        WR_ACK   = 3'd4
    } state_t;

endpackage

// File: rtl/main_mem_array.sv
// mem_array: DEPTH_WORDS x 32 storage, synchronous write, combinational read.
// Contents are never reset.
module mem_array
    import main_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/main_mem.sv
// main_mem: line-burst main memory serving cache refills and writebacks.
// Optional build macro MAIN_MEM_CRITICAL_WORD_FIRST_EN: refill starts at the requested word.
module main_mem
    import main_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int LINE_WORDS  = DEF_LINE_WORDS,
    parameter int LATENCY     = DEF_LATENCY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] wdata,
    input  logic        wdata_valid,
    output logic        wdata_ready,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        rdata_last,
    output logic        wr_done
);

    localparam int AW  = $clog2(DEPTH_WORDS);
    localparam int OW  = $clog2(LINE_WORDS);
    localparam int LCW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [OW-1:0]  LAST_BEAT = OW'(LINE_WORDS - 1);
    localparam logic [LCW-1:0] LAST_LAT  = LCW'(LATENCY - 1);

    state_t state, state_nxt;

    logic [OW-1:0]    beat_cnt;
    logic [LCW-1:0]   lat_cnt;
    logic [AW-OW-1:0] line_q;
    logic [OW-1:0]    off_q;
    logic             wr_q;

    logic             accept;
    logic             beat_hs;
    logic [OW-1:0]    req_off;
    logic [OW-1:0]    rd_off;
    logic [31:0]      arr_rdata;
    logic             unused_addr_bits;

    assign accept  = req_valid && req_ready;
    assign beat_hs = wdata_valid && wdata_ready;

`ifdef MAIN_MEM_CRITICAL_WORD_FIRST_EN
    assign req_off = req_write ? '0 : req_addr[OW+1:2];
`else
    assign req_off = '0;
`endif

    // Byte-lane bits and address bits above the storage size are dropped.
    assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[OW+1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = req_write ? WR_BURST : LAT;
                end
            end
            WR_BURST: begin
                if (beat_hs && beat_cnt == LAST_BEAT) begin
                    state_nxt = LAT;
                end
            end
            LAT: begin
                if (lat_cnt == LAST_LAT) begin
                    state_nxt = wr_q ? WR_ACK : RD_BURST;
                end
            end
            RD_BURST: begin
                if (beat_cnt == LAST_BEAT) begin
                    state_nxt = IDLE;
                end
            end
            WR_ACK:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are forced low while rst is high, even before the reset edge lands.
    always_comb begin
        req_ready   = 1'b0;
        wdata_ready = 1'b0;
        rdata_valid = 1'b0;
        rdata_last  = 1'b0;
        wr_done     = 1'b0;
        if (!rst) begin
            case (state)
                IDLE:     req_ready   = 1'b1;
                WR_BURST: wdata_ready = 1'b1;
                RD_BURST: begin
                    rdata_valid = 1'b1;
                    rdata_last  = (beat_cnt == LAST_BEAT);
                end
                WR_ACK:   wr_done     = 1'b1;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
            lat_cnt  <= '0;
        end else begin
            case (state)
                WR_BURST: if (beat_hs) beat_cnt <= beat_cnt + 1'b1;
                RD_BURST: beat_cnt <= beat_cnt + 1'b1;
                default:  beat_cnt <= '0;
            endcase
            lat_cnt <= (state == LAT && lat_cnt != LAST_LAT) ? lat_cnt + 1'b1 : '0;
        end
    end

    // Request attributes are plain data: captured on acceptance, never reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            line_q <= req_addr[AW+1:OW+2];
            off_q  <= req_off;
            wr_q   <= req_write;
        end
    end

    // Beat offset wraps naturally inside the line through OW-bit addition.
    assign rd_off = off_q + beat_cnt;
    assign rdata  = rdata_valid ? arr_rdata : '0;

    mem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk  (clk),
        .we   (beat_hs),
        .waddr({line_q, beat_cnt}),
        .wdata(wdata),
        .raddr({line_q, rd_off}),
        .rdata(arr_rdata)
    );

endmodule

// File: tb/tb_main_mem.sv
// Randomised bench for main_mem against a transaction-level timing/storage model,
// plus directed scenarios with hand-computed literal expectations.
module tb_main_mem;

    localparam int LW    = 4;
    localparam int LAT   = 3;
    localparam int DEPTH = 65536;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] wdata = '0;
    logic        wdata_valid = 1'b0;
    logic        req_ready, wdata_ready, rdata_valid, rdata_last, wr_done;
    logic [31:0] rdata;

    main_mem #(
        .DEPTH_WORDS(DEPTH),
        .LINE_WORDS (LW),
        .LATENCY    (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .wdata      (wdata),
        .wdata_valid(wdata_valid),
        .wdata_ready(wdata_ready),
        .rdata      (rdata),
        .rdata_valid(rdata_valid),
        .rdata_last (rdata_last),
        .wr_done    (wr_done)
    );

    always #5 clk = ~clk;

    int     vectors = 0;
    int     miscompares = 0;
    longint cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: got no event within bound, required event (cycle %0d)", name, cyc);
    endtask

    // ---------------- reference model ----------------
    logic [31:0]  mmem [int unsigned];
    longint       free_at = 0;
    longint       done_at = -100;
    longint       rd_first = -100;
    bit           wr_open = 0;
    int unsigned  wr_beats = 0;
    int unsigned  m_line = 0;
    int unsigned  m_off = 0;

    typedef struct {
        longint      c;
        logic [31:0] d;
        bit          last;
    } beat_t;
    beat_t obs[$];

    always @(negedge clk) begin
        bit          e_ready, e_wready, e_rv, e_last, e_done, known;
        logic [31:0] e_data;
        longint      k;
        int unsigned idx, word;
        beat_t       b;

        e_ready = 0; e_wready = 0; e_rv = 0; e_last = 0; e_done = 0;
        e_data = '0; known = 1; k = cyc - rd_first;
        if (!rst) begin
            e_ready  = !wr_open && (cyc >= free_at);
            e_wready = wr_open;
            e_rv     = (k >= 0) && (k < LW);
            e_last   = e_rv && (k == LW - 1);
            e_done   = (cyc == done_at);
        end
        if (e_rv) begin
            idx = m_line + int'(unsigned'((longint'(m_off) + k) % LW));
            if (mmem.exists(idx)) e_data = mmem[idx];
            else known = 0;
        end
        chk("req_ready",   32'(req_ready),   32'(e_ready));
        chk("wdata_ready", 32'(wdata_ready), 32'(e_wready));
        chk("rdata_valid", 32'(rdata_valid), 32'(e_rv));
        chk("rdata_last",  32'(rdata_last),  32'(e_last));
        chk("wr_done",     32'(wr_done),     32'(e_done));
        if (known) chk("rdata", rdata, e_data);
        if (rdata_valid) begin
            b.c = cyc; b.d = rdata; b.last = rdata_last;
            obs.push_back(b);
        end

        // advance the model across the coming edge
        if (rst) begin
            wr_open  = 0;
            free_at  = 0;
            done_at  = -100;
            rd_first = -100;
        end else if (e_ready && req_valid) begin
            word   = (req_addr >> 2) % DEPTH;
            m_line = word - (word % LW);
            if (req_write) begin
                wr_open  = 1;
                wr_beats = 0;
                m_off    = 0;
            end else begin
`ifdef MAIN_MEM_CRITICAL_WORD_FIRST_EN
                m_off = word % LW;
`else
                m_off = 0;
`endif
                rd_first = cyc + LAT + 1;
                free_at  = cyc + LAT + LW + 1;
            end
        end else if (wr_open && wdata_valid) begin
            mmem[m_line + wr_beats] = wdata;
            wr_beats++;
            if (wr_beats == LW) begin
                wr_open = 0;
                done_at = cyc + LAT + 1;
                free_at = cyc + LAT + 2;
            end
        end
    end

    // ---------------- driver tasks ----------------
    logic [31:0] wbuf [LW];

    task automatic wait_accept(output longint acc);
        bit ok;
        ok = 0;
        acc = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req_ready) begin
                acc = cyc;
                ok = 1;
                break;
            end
        end
        if (!ok) timeout("accept");
        @(posedge clk); #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] pat, input int pat_len,
                            output int ndone);
        longint acc;
        int     n, s;
        bit     v;
        req_valid = 1; req_write = 1; req_addr = addr; wdata_valid = 0;
        wait_accept(acc);
        req_valid = 0;
        n = 0; s = 0;
        while (n < LW && s < 200) begin
            v = (pat_len > 0) ? pat[s % pat_len] : ($urandom_range(0, 99) < 70);
            wdata_valid = v;
            wdata = v ? wbuf[n] : $urandom;
            @(negedge clk);
            if (wdata_valid && wdata_ready) n++;
            @(posedge clk); #1;
            s++;
        end
        wdata_valid = 0;
        if (n < LW) timeout("write_beats");
        ndone = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (wr_done) ndone++;
            if (req_ready) break;
        end
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [31:0] addr, output longint acc);
        bit ok;
        obs.delete();
        req_valid = 1; req_write = 0; req_addr = addr;
        wait_accept(acc);
        req_valid = 0;
        ok = 0;
        for (int i = 0; i < LAT + LW + 10; i++) begin
            wdata_valid = $urandom_range(0, 1);
            wdata = $urandom;
            @(posedge clk); #1;
            if (obs.size() >= LW) begin
                ok = 1;
                break;
            end
        end
        wdata_valid = 0;
        if (!ok) timeout("read_beats");
    endtask

    task automatic check_line(input string tag, input longint acc,
                              input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [31:0] e3);
        logic [31:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        chk({tag, "_nbeats"}, 32'(obs.size()), 32'd4);
        if (obs.size() == LW) begin
            for (int k = 0; k < LW; k++) begin
                chk({tag, "_beat_cycle"}, 32'(obs[k].c - acc), 32'(4 + k));
                chk({tag, "_data"}, obs[k].d, e[k]);
                chk({tag, "_last"}, 32'(obs[k].last), 32'(k == 3));
            end
        end
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] lines [6];

    initial begin
        longint      acc, a1, a2;
        int          nd;
        bit          ok, any_last;
        logic [31:0] sv [LW];
        logic [31:0] addr;

        lines[0] = 32'h0000_0100; lines[1] = 32'h0000_2000; lines[2] = 32'h0000_0040;
        lines[3] = 32'hFFFF_FFF0; lines[4] = 32'h1234_5670; lines[5] = 32'h0003_0000;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("ready_after_reset", 32'(req_ready), 32'd1);
        @(posedge clk); #1;

        // preload words 4..7
        wbuf[0] = 32'hA0; wbuf[1] = 32'hA1; wbuf[2] = 32'hA2; wbuf[3] = 32'hA3;
        do_write(32'h0000_0010, 32'hF, 4, nd);
        chk("preload_wr_done_count", 32'(nd), 32'd1);

        do_read(32'h0000_0010, acc);
        check_line("refill_10", acc, 32'hA0, 32'hA1, 32'hA2, 32'hA3);

        do_read(32'h0000_0018, acc);
`ifdef MAIN_MEM_CRITICAL_WORD_FIRST_EN
        check_line("refill_18", acc, 32'hA2, 32'hA3, 32'hA0, 32'hA1);
`else
        check_line("refill_18", acc, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
`endif

        // gapped writeback, valid pattern 1,0,1,1,0,1
        wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33; wbuf[3] = 32'h44;
        do_write(32'h0000_0040, 32'b101101, 6, nd);
        chk("gapped_wr_done_count", 32'(nd), 32'd1);
        do_read(32'h0000_0040, acc);
        check_line("refill_40", acc, 32'h11, 32'h22, 32'h33, 32'h44);

        // req_valid held high across a whole refill
        obs.delete();
        req_valid = 1; req_write = 0; req_addr = 32'h0000_0010;
        wait_accept(a1);
        req_addr = 32'h0000_0040;
        wait_accept(a2);
        req_valid = 0;
        chk("hold_accept_gap", 32'(a2 - a1), 32'd8);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (obs.size() >= 2 * LW) begin
                ok = 1;
                break;
            end
        end
        if (!ok) timeout("hold_beats");
        repeat (3) begin @(posedge clk); #1; end
        chk("hold_beat_count", 32'(obs.size()), 32'd8);

        // reset during the second refill beat
        obs.delete();
        req_valid = 1; req_write = 0; req_addr = 32'h0000_0010;
        wait_accept(acc);
        req_valid = 0;
        for (int i = 0; i < 20; i++) begin
            if (cyc == acc + LAT + 2) break;
            @(posedge clk); #1;
        end
        rst = 1;
        @(negedge clk);
        chk("rst_mid_rdata_valid", 32'(rdata_valid), 32'd0);
        chk("rst_mid_rdata", rdata, 32'd0);
        chk("rst_mid_rdata_last", 32'(rdata_last), 32'd0);
        @(posedge clk); #1;
        rst = 0;
        repeat (3) begin @(posedge clk); #1; end
        any_last = 0;
        foreach (obs[i]) if (obs[i].last) any_last = 1;
        chk("rst_beats_before_abort", 32'(obs.size()), 32'd1);
        chk("rst_no_last", 32'(any_last), 32'd0);
        do_read(32'h0000_0040, acc);
        check_line("after_rst_40", acc, 32'h11, 32'h22, 32'h33, 32'h44);

        // top of the address space folds into words 0xFFFC..0xFFFF
        for (int i = 0; i < LW; i++) begin
            sv[i] = $urandom;
            wbuf[i] = sv[i];
        end
        do_write(32'hFFFF_FFF0, 32'h0, 0, nd);
        chk("top_wr_done_count", 32'(nd), 32'd1);
        do_read(32'h0003_FFF0, acc);
        check_line("alias_fffc", acc, sv[0], sv[1], sv[2], sv[3]);

        // randomized traffic
        for (int l = 0; l < 6; l++) begin
            for (int i = 0; i < LW; i++) wbuf[i] = $urandom;
            do_write(lines[l], 32'h0, 0, nd);
        end
        for (int t = 0; t < 80; t++) begin
            addr = lines[$urandom_range(0, 5)] | (32'($urandom_range(0, LW - 1)) << 2)
                   | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < LW; i++) wbuf[i] = $urandom;
                do_write(addr, 32'h0, 0, nd);
            end else begin
                do_read(addr, acc);
            end
            repeat ($urandom_range(0, 3)) begin
                wdata_valid = $urandom_range(0, 1);
                wdata = $urandom;
                @(posedge clk); #1;
            end
            wdata_valid = 0;
        end

        repeat (5) begin @(posedge clk); #1; end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, required $finish before time limit");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog");
    end

endmodule
